// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC generator and in-order prefetch FIFO feeding decode.
// Ports: clk, reset (async, active-low); branch_taken/branch_tgt and jump/jump_tgt
// redirect fetch, with jump taking priority; imem_req/addr/gnt/rvalid/rdata form the
// memory side; instr_valid/ready/instr/pc carry instructions to decode.
// The fetch_misaligned flag exists only when FETCH_MISALIGN_CHK_EN is defined.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter int unsigned     PC_STEP    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_tgt,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_tgt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            fetch_misaligned
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   outs_q, outs_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]   tw_q, tw_d, tr_q, tr_d;
  logic            mis_q, mis_d;

  logic [XLEN-1:0] instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [XLEN-1:0] tag_mem   [FIFO_DEPTH];

  logic            redir, credit, req, accept;
  logic            push, pop, drop;
  logic [XLEN-1:0] tgt;
  logic [SW-1:0]   used;

  always_comb begin
    redir  = jump | branch_taken;
    tgt    = jump ? jump_tgt : branch_tgt;
    // Discarded in-flight requests still hold credit until they drain.
    used   = SW'(cnt_q) + SW'(outs_q) + SW'(disc_q);
    credit = used < SW'(FIFO_DEPTH);
    req    = reset & credit & ~redir & ~mis_q;
    accept = req & imem_gnt;
    drop   = imem_rvalid & ((disc_q != '0) | redir);
    push   = imem_rvalid & ~drop;
    pop    = (cnt_q != '0) & instr_ready & ~redir;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;
    outs_d     = outs_q;
    disc_d     = disc_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    tw_d       = tw_q + PW'(accept);
    tr_d       = tr_q + PW'(imem_rvalid);
    if (redir) begin
      fetch_pc_d = tgt;
      cnt_d      = '0;
      wr_d       = '0;
      rd_d       = '0;
      outs_d     = '0;
      // Everything still in flight, minus a response landing now, is dropped.
      disc_d     = outs_q + disc_q - CW'(imem_rvalid);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      wr_d   = wr_q + PW'(push);
      rd_d   = rd_q + PW'(pop);
      outs_d = outs_q + CW'(accept) - CW'(push);
      disc_d = disc_q - CW'(drop);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    mis_d = redir ? (tgt[1:0] != 2'b00) : mis_q;
`else
    mis_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      cnt_q      <= '0;
      outs_q     <= '0;
      disc_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      tw_q       <= '0;
      tr_q       <= '0;
      mis_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      outs_q     <= outs_d;
      disc_q     <= disc_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      tw_q       <= tw_d;
      tr_q       <= tr_d;
      mis_q      <= mis_d;
    end
  end

  // Payload storage; pointers above decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_q] <= imem_rdata;
      pc_mem[wr_q]    <= tag_mem[tr_q];
    end
    if (accept) tag_mem[tw_q] <= fetch_pc_q;
  end

  assign imem_req         = req;
  assign imem_addr        = fetch_pc_q;
  assign instr_valid      = cnt_q != '0;
  assign instr            = instr_valid ? instr_mem[rd_q] : '0;
  assign pc               = instr_valid ? pc_mem[rd_q] : '0;
  assign fetch_misaligned = mis_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed bench for fetch_prefetch_unit.
// Bench-side imem grants every request and answers in order.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_tgt = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_tgt = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fetch_misaligned;

  fetch_prefetch_unit dut (
    .clk(clk),
    .reset(reset),
    .branch_taken(branch_taken),
    .branch_tgt(branch_tgt),
    .jump(jump),
    .jump_tgt(jump_tgt),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .pc(pc),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          grants;
  bit          found;
  bit          rsp_en = 1'b1;
  logic [31:0] pend[$];
  logic [31:0] popped[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One cycle: set inputs at negedge, answer oldest grant, then record.
  task automatic step(input bit rdy, input bit br, input logic [31:0] bt,
                      input bit jp, input logic [31:0] jt);
    @(negedge clk);
    reset        = 1'b1;
    instr_ready  = rdy;
    branch_taken = br;
    branch_tgt   = bt;
    jump         = jp;
    jump_tgt     = jt;
    if (rsp_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    if (imem_req && imem_gnt) pend.push_back(imem_addr);
    if (instr_valid && instr_ready && !(br || jp)) popped.push_back(pc);
  endtask

  task automatic run(input bit rdy);
    step(rdy, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    instr_ready  = 1'b0;
    imem_rvalid  = 1'b0;
    rsp_en       = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    pend.delete();
    popped.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      run(1'b0);
      if (instr_valid) found = 1'b1;
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_instr"}, instr, mem_data(exp_pc));
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_mis", 32'(fetch_misaligned), 32'd0);

    // 1: streaming, one instruction per cycle after two-cycle fill
    for (int i = 0; i < 10; i++) begin
      run(1'b1);
      chk("s1_req", 32'(imem_req), 32'd1);
      chk("s1_addr", imem_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("s1_pc", pc, 32'(4 * (i - 2)));
        chk("s1_instr", instr, mem_data(32'(4 * (i - 2))));
      end
    end

    // 2: decode stalls; credit caps requests at four
    do_reset();
    grants = 0;
    for (int i = 0; i < 10; i++) begin
      run(1'b0);
      if (imem_req) grants++;
    end
    chk("s2_grants", 32'(grants), 32'd4);
    chk("s2_req_off", 32'(imem_req), 32'd0);
    chk("s2_head_pc", pc, 32'h0);
    run(1'b1);
    chk("s2_req_full", 32'(imem_req), 32'd0);
    run(1'b1);
    chk("s2_resume_req", 32'(imem_req), 32'd1);
    chk("s2_resume_addr", imem_addr, 32'h10);
    run(1'b1);
    run(1'b1);
    chk("s2_npop", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("s2_pop_pc", popped[i], 32'(4 * i));

    // 3: branch with two requests in flight
    do_reset();
    rsp_en = 1'b0;
    run(1'b1);
    run(1'b1);
    step(1'b1, 1'b1, 32'h08, 1'b0, '0);
    chk("s3_req_redir", 32'(imem_req), 32'd0);
    rsp_en = 1'b1;
    run(1'b1);
    chk("s3_req", 32'(imem_req), 32'd1);
    chk("s3_addr", imem_addr, 32'h08);
    wait_valid("s3", 32'h08);

    // 4: jump wins over branch
    do_reset();
    run(1'b1);
    run(1'b1);
    step(1'b1, 1'b1, 32'h20, 1'b1, 32'h0C);
    chk("s4_req_redir", 32'(imem_req), 32'd0);
    run(1'b1);
    chk("s4_req", 32'(imem_req), 32'd1);
    chk("s4_addr", imem_addr, 32'h0C);
    wait_valid("s4", 32'h0C);

    // 5: redirect together with rvalid and a pop attempt
    do_reset();
    run(1'b1);
    run(1'b1);
    run(1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b0, '0);
    chk("s5_head_pc", pc, 32'h04);
    run(1'b1);
    chk("s5_empty", 32'(instr_valid), 32'd0);
    chk("s5_req", 32'(imem_req), 32'd1);
    chk("s5_addr", imem_addr, 32'h40);
    wait_valid("s5", 32'h40);

    // 6: misaligned redirect target
    do_reset();
    run(1'b1);
    run(1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 32'h0E);
`ifdef FETCH_MISALIGN_CHK_EN
    run(1'b1);
    chk("s6_mis_set", 32'(fetch_misaligned), 32'd1);
    chk("s6_halt", 32'(imem_req), 32'd0);
    run(1'b1);
    run(1'b1);
    chk("s6_halt_hold", 32'(imem_req), 32'd0);
    chk("s6_mis_hold", 32'(fetch_misaligned), 32'd1);
    step(1'b1, 1'b1, 32'h10, 1'b0, '0);
    run(1'b1);
    chk("s6_mis_clr", 32'(fetch_misaligned), 32'd0);
    chk("s6_req", 32'(imem_req), 32'd1);
    chk("s6_addr", imem_addr, 32'h10);
    wait_valid("s6", 32'h10);
`else
    run(1'b1);
    chk("s6_mis_tied", 32'(fetch_misaligned), 32'd0);
    chk("s6_req", 32'(imem_req), 32'd1);
    chk("s6_addr", imem_addr, 32'h0E);
`endif

    // 7: PC wraps modulo 2^32
    do_reset();
    step(1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
    run(1'b1);
    chk("s7_addr_top", imem_addr, 32'hFFFF_FFFC);
    run(1'b1);
    chk("s7_addr_wrap", imem_addr, 32'h0);
    wait_valid("s7", 32'hFFFF_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch stage: PC generator plus in-order prefetch buffer feeding decode over a valid/ready handshake.
- Redirects: branch and jump, with defined priority.
- Instruction memory: request/grant/response interface, multiple requests outstanding.
- Redirect flushes buffered instructions and squashes in-flight responses.
- Sits between imem and decode; replaces the single-cycle PC/instruction path.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 4, prefetch buffer entries (power of 2, >=2); also caps outstanding requests
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
branch_taken  input  1  branch redirect request
branch_tgt  input  XLEN  branch target
jump  input  1  jump redirect request
jump_tgt  input  XLEN  jump target
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid (in order, >=1 cycle after grant)
imem_rdata  input  XLEN  response instruction
instr_valid  output  1  buffer head valid
instr_ready  input  1  decode accepts head
instr  output  XLEN  head instruction
pc  output  XLEN  PC of head instruction
fetch_misaligned  output  1  misaligned redirect flag (optional feature only, else tied 0)

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; all outputs 0 except imem_addr=RESET_PC.
- Redirect priority: jump over branch_taken. Target = jump ? jump_tgt : branch_tgt.
- Credit rule: imem_req=1 iff (fifo_count + outstanding) < FIFO_DEPTH, no redirect this cycle, and not halted.
  - imem_addr=fetch_pc (combinational from register).
- Request accepted on imem_req & imem_gnt:
  - fetch_pc += PC_STEP (wraps modulo 2^XLEN).
  - outstanding += 1; the address is pushed into an internal PC tag queue.
- Response (imem_rvalid):
  - If discard>0: drop it, discard -= 1, pop the tag.
  - Otherwise push {tag, imem_rdata} into the FIFO; outstanding -= 1.
  - Visible on instr/pc the cycle after rvalid; no bypass.
- Output: instr_valid = FIFO non-empty. Pop on instr_valid & instr_ready. Push and pop in the same cycle leaves the count unchanged.
- Redirect cycle (jump | branch_taken):
  - fetch_pc <= target.
  - FIFO cleared.
  - Every in-flight request, including one granted this cycle (none are, because imem_req is held 0), becomes discard: discard <= outstanding - (response this cycle ? 1 : 0) + discard adjustments; outstanding <= 0 for credit purposes after discard.
  - A pop in the redirect cycle is ignored.
  - A response arriving in the redirect cycle is discarded.
  - First new request: imem_req=1 with addr=target in the cycle after the redirect.
- Credit counts discard entries as outstanding until their responses drain.
- Full: with fifo_count + outstanding + discard = FIFO_DEPTH, imem_req=0. Responses never overflow the FIFO.
- Asserting reset mid-operation clears all state immediately. In-flight responses after reset release are ignored only if discard was loaded; the imem side must be reset together with this block.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined: a redirect target with target[1:0]!=0 sets fetch_misaligned=1 (sticky) and halts fetch (imem_req=0); the FIFO is still flushed. The next aligned redirect clears the flag and resumes. fetch_misaligned clears on reset.
- Undefined: no check; target used as given; fetch_misaligned tied 0.

Test Plan:
1. Reset release, imem_gnt=1, 1-cycle rvalid, instr_ready=1 -> imem_addr 0x0,0x4,0x8,...; pc/instr stream in order, one per cycle after 2-cycle fill.
2. instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 requests issued; imem_req=0 thereafter; resumes with addr 0x10 when ready rises.
3. branch_taken=1, branch_tgt=0x08 with 2 requests in flight -> both responses dropped; next imem_addr=0x08; first instr_valid has pc=0x08.
4. jump=1 (jump_tgt=0x0C) and branch_taken=1 (branch_tgt=0x20) in the same cycle -> fetch resumes at 0x0C.
5. Redirect on the same cycle as rvalid and instr_ready -> the response is discarded, no pop is observed, and the FIFO is empty next cycle.
6. With FETCH_MISALIGN_CHK_EN: jump_tgt=0x0E -> fetch_misaligned=1, imem_req stays 0; then branch to 0x10 -> flag clears and fetch resumes at 0x10.
